// File: rtl/pc_fetch_stage.sv
// PC register and instruction-fetch handshake feeding the IF/ID register.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Pc_In,
    input  logic        Do_Stall,
    input  logic        Is_Branch_Taken,
    output logic [31:0] Pc_Out,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Gnt,
    input  logic        Imem_Rvalid,
    input  logic [31:0] Imem_Rdata,
    output logic        If_Valid,
    output logic [31:0] If_Pc,
    output logic [31:0] If_Instr,
    output logic        Fetch_Err
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state, state_next;
    logic        kill, kill_next;
    logic        advance, load, capture, timeout;
    logic [31:0] load_pc, load_instr;
    logic [31:0] hold_pc, hold_instr;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;
    assign wait_cnt_inc = wait_cnt + 16'd1;
`endif

    assign Imem_Req  = (state == S_REQ);
    assign Imem_Addr = Pc_Out;

    always_comb begin
        state_next = state;
        kill_next  = kill;
        advance    = 1'b0;
        load       = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        load_pc    = hold_pc;
        load_instr = hold_instr;
        case (state)
            S_REQ: begin
                if (Imem_Gnt) begin
                    state_next = S_WAIT;
                    if (Is_Branch_Taken) begin
                        advance   = 1'b1;
                        kill_next = 1'b1;
                    end
                end else if (Is_Branch_Taken) begin
                    advance = 1'b1;
                end
            end
            S_WAIT: begin
                if (Imem_Rvalid) begin
                    if (kill) begin
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                        advance    = Is_Branch_Taken;
                    end else if (Is_Branch_Taken) begin
                        advance    = 1'b1;
                        state_next = S_REQ;
                    end else if (Do_Stall) begin
                        capture    = 1'b1;
                        state_next = S_HOLD;
                    end else begin
                        load       = 1'b1;
                        load_pc    = Pc_Out;
                        load_instr = Imem_Rdata;
                        advance    = 1'b1;
                        state_next = S_REQ;
                    end
                end else begin
                    // A branch while waiting marks the in-flight response as wrong-path.
                    if (Is_Branch_Taken) begin
                        kill_next = 1'b1;
                        advance   = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (wait_cnt_inc == 16'(TIMEOUT_CYCLES)) begin
                        timeout    = 1'b1;
                        kill_next  = 1'b1;
                        state_next = S_REQ;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (Is_Branch_Taken) begin
                    advance    = 1'b1;
                    state_next = S_REQ;
                end else if (!Do_Stall) begin
                    load       = 1'b1;
                    advance    = 1'b1;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_REQ;
            kill   <= 1'b0;
            Pc_Out <= RESET_PC;
        end else begin
            state <= state_next;
            kill  <= kill_next;
            if (advance) Pc_Out <= Pc_In;
        end
    end

    // Response captured while decode is stalled
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_pc    <= 32'd0;
            hold_instr <= NOP_INSTR;
        end else if (capture) begin
            hold_pc    <= Pc_Out;
            hold_instr <= Imem_Rdata;
        end
    end

    // IF/ID register: flush beats stall beats load beats bubble
    always_ff @(posedge Clk) begin
        if (Reset) begin
            If_Valid <= 1'b0;
            If_Pc    <= 32'd0;
            If_Instr <= NOP_INSTR;
        end else if (Is_Branch_Taken) begin
            If_Valid <= 1'b0;
            If_Instr <= NOP_INSTR;
        end else if (Do_Stall) begin
            If_Valid <= If_Valid;
        end else if (load) begin
            If_Valid <= 1'b1;
            If_Pc    <= load_pc;
            If_Instr <= load_instr;
        end else begin
            If_Valid <= 1'b0;
            If_Instr <= NOP_INSTR;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt  <= 16'd0;
            Fetch_Err <= 1'b0;
        end else begin
            if (state != S_WAIT) wait_cnt <= 16'd0;
            else if (!Imem_Rvalid) wait_cnt <= wait_cnt_inc;
            if (timeout) Fetch_Err <= 1'b1;
        end
    end
`else
    // Without the timeout Fetch_Err is constant zero.
    assign Fetch_Err = 1'b0 & (TIMEOUT_CYCLES != 0) & timeout;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed-vector bench for pc_fetch_stage; covers the timeout path when FETCH_TIMEOUT_EN is defined.
module tb_pc_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Pc_In;
    logic        Do_Stall;
    logic        Is_Branch_Taken;
    logic [31:0] Pc_Out;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Gnt;
    logic        Imem_Rvalid;
    logic [31:0] Imem_Rdata;
    logic        If_Valid;
    logic [31:0] If_Pc;
    logic [31:0] If_Instr;
    logic        Fetch_Err;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 Clk = ~Clk;

    pc_fetch_stage #(
        .RESET_PC      (32'h0000_0000),
        .NOP_INSTR     (32'h0000_0013),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Pc_In          (Pc_In),
        .Do_Stall       (Do_Stall),
        .Is_Branch_Taken(Is_Branch_Taken),
        .Pc_Out         (Pc_Out),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Gnt       (Imem_Gnt),
        .Imem_Rvalid    (Imem_Rvalid),
        .Imem_Rdata     (Imem_Rdata),
        .If_Valid       (If_Valid),
        .If_Pc          (If_Pc),
        .If_Instr       (If_Instr),
        .Fetch_Err      (Fetch_Err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic br, input logic stall, input logic [31:0] pcin);
        Imem_Gnt        = gnt;
        Imem_Rvalid     = rv;
        Imem_Rdata      = rdata;
        Is_Branch_Taken = br;
        Do_Stall        = stall;
        Pc_In           = pcin;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check("rst_pc", Pc_Out, 32'h0);
        check("rst_req", 32'(Imem_Req), 32'd1);
        check("rst_addr", Imem_Addr, 32'h0);
        check("rst_valid", 32'(If_Valid), 32'd0);
        check("rst_ifpc", If_Pc, 32'h0);
        check("rst_instr", If_Instr, NOP);
        check("rst_err", 32'(Fetch_Err), 32'd0);
        Reset = 1'b0;

        // Back-to-back fetches
        drive(1, 0, 32'h0, 0, 0, 32'h4);
        check("f0_req", 32'(Imem_Req), 32'd0);
        check("f0_pc", Pc_Out, 32'h0);
        drive(0, 1, 32'h1, 0, 0, 32'h4);
        check("f0_valid", 32'(If_Valid), 32'd1);
        check("f0_ifpc", If_Pc, 32'h0);
        check("f0_instr", If_Instr, 32'h1);
        check("f0_addr", Imem_Addr, 32'h4);
        drive(1, 0, 32'h0, 0, 0, 32'h8);
        check("bub_valid", 32'(If_Valid), 32'd0);
        check("bub_instr", If_Instr, NOP);
        drive(0, 1, 32'h5, 0, 0, 32'h8);
        check("f4_ifpc", If_Pc, 32'h4);
        check("f4_instr", If_Instr, 32'h5);
        check("f4_pc", Pc_Out, 32'h8);

        // Stall on response for PC 8
        drive(1, 0, 32'h0, 0, 0, 32'hC);
        drive(0, 1, 32'h9, 0, 1, 32'hC);
        check("st_pc", Pc_Out, 32'h8);
        check("st_req", 32'(Imem_Req), 32'd0);
        drive(0, 0, 32'h0, 0, 1, 32'hC);
        drive(0, 0, 32'h0, 0, 1, 32'hC);
        check("st_ifpc", If_Pc, 32'h4);
        check("st_req2", 32'(Imem_Req), 32'd0);
        drive(0, 0, 32'h0, 0, 0, 32'hC);
        check("rel_ifpc", If_Pc, 32'h8);
        check("rel_instr", If_Instr, 32'h9);
        check("rel_valid", 32'(If_Valid), 32'd1);
        check("rel_pc", Pc_Out, 32'hC);
        check("rel_req", 32'(Imem_Req), 32'd1);

        // Branch while waiting: response killed
        drive(1, 0, 32'h0, 0, 0, 32'h10);
        drive(0, 0, 32'h0, 1, 0, 32'h100);
        check("bw_valid", 32'(If_Valid), 32'd0);
        check("bw_instr", If_Instr, NOP);
        check("bw_pc", Pc_Out, 32'h100);
        check("bw_req", 32'(Imem_Req), 32'd0);
        drive(0, 1, 32'hD, 0, 0, 32'h104);
        check("bw_kill_valid", 32'(If_Valid), 32'd0);
        check("bw_kill_req", 32'(Imem_Req), 32'd1);
        check("bw_kill_addr", Imem_Addr, 32'h100);

        // Branch on the response cycle
        drive(1, 0, 32'h0, 0, 0, 32'h104);
        drive(0, 1, 32'h101, 1, 0, 32'h300);
        check("br_rv_valid", 32'(If_Valid), 32'd0);
        check("br_rv_addr", Imem_Addr, 32'h300);
        check("br_rv_req", 32'(Imem_Req), 32'd1);

        // Branch with grant
        drive(1, 0, 32'h0, 1, 0, 32'h200);
        check("bg_pc", Pc_Out, 32'h200);
        check("bg_req", 32'(Imem_Req), 32'd0);
        drive(0, 1, 32'h301, 0, 0, 32'h204);
        check("bg_kill_valid", 32'(If_Valid), 32'd0);
        check("bg_kill_addr", Imem_Addr, 32'h200);
        check("bg_kill_req", 32'(Imem_Req), 32'd1);
        drive(1, 0, 32'h0, 0, 0, 32'h204);
        drive(0, 1, 32'h201, 0, 0, 32'h204);
        check("bg_ifpc", If_Pc, 32'h200);
        check("bg_instr", If_Instr, 32'h201);
        check("bg_valid", 32'(If_Valid), 32'd1);
        check("bg_pc2", Pc_Out, 32'h204);

        // Branch and stall together: flush wins
        drive(0, 0, 32'h0, 1, 1, 32'h500);
        check("bs_pc", Pc_Out, 32'h500);
        check("bs_valid", 32'(If_Valid), 32'd0);
        check("bs_instr", If_Instr, NOP);
        check("bs_addr", Imem_Addr, 32'h500);

`ifdef FETCH_TIMEOUT_EN
        drive(1, 0, 32'h0, 0, 0, 32'h504);
        drive(0, 0, 32'h0, 0, 0, 32'h504);
        drive(0, 0, 32'h0, 0, 0, 32'h504);
        drive(0, 0, 32'h0, 0, 0, 32'h504);
        check("to_err_early", 32'(Fetch_Err), 32'd0);
        check("to_req_early", 32'(Imem_Req), 32'd0);
        drive(0, 0, 32'h0, 0, 0, 32'h504);
        check("to_err", 32'(Fetch_Err), 32'd1);
        check("to_req", 32'(Imem_Req), 32'd1);
        check("to_addr", Imem_Addr, 32'h500);
        drive(1, 0, 32'h0, 0, 0, 32'h504);
        drive(0, 1, 32'hBAD, 0, 0, 32'h504);
        check("to_late_valid", 32'(If_Valid), 32'd0);
        check("to_late_req", 32'(Imem_Req), 32'd1);
        check("to_late_pc", Pc_Out, 32'h500);
        drive(1, 0, 32'h0, 0, 0, 32'h504);
        drive(0, 1, 32'h501, 0, 0, 32'h504);
        check("to_ifpc", If_Pc, 32'h500);
        check("to_instr", If_Instr, 32'h501);
        check("to_err_sticky", 32'(Fetch_Err), 32'd1);
`else
        drive(1, 0, 32'h0, 0, 0, 32'h504);
        for (int i = 0; i < 6; i++) drive(0, 0, 32'h0, 0, 0, 32'h504);
        check("nto_req", 32'(Imem_Req), 32'd0);
        check("nto_err", 32'(Fetch_Err), 32'd0);
        drive(0, 1, 32'h501, 0, 0, 32'h504);
        check("nto_ifpc", If_Pc, 32'h500);
        check("nto_instr", If_Instr, 32'h501);
        check("nto_pc", Pc_Out, 32'h504);
`endif

        // Reset in the middle of a transaction
        drive(1, 0, 32'h0, 0, 0, 32'h600);
        Reset = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h600);
        Reset = 1'b0;
        check("mr_req", 32'(Imem_Req), 32'd1);
        check("mr_pc", Pc_Out, 32'h0);
        check("mr_ifpc", If_Pc, 32'h0);
        check("mr_err", 32'(Fetch_Err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
